// File: rtl/la_lfsr_selftest.sv
// LA-controlled Galois LFSR self-test: load seed/N/signature, step N times, compare, report PASS/FAIL.
// Latency: start edge at T -> LOAD T+1, CMP T+N+2, PASS/FAIL T+N+3.
// No backpressure: firmware polls state/status; abort returns to IDLE in one cycle.
module la_lfsr_selftest #(
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] POLY   = 32'h80200003,
  parameter int                CNT_W  = 16
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [127:0] la_data_in,
  input  logic [127:0] la_oenb,
  output logic [127:0] la_data_out,
  output logic [37:0]  io_out,
  output logic [37:0]  io_oeb
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    CMP  = 3'd3,
    PASS = 3'd4,
    FAIL = 3'd5
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0]  n;
    logic [LFSR_W-1:0] sig;
    logic [LFSR_W-1:0] seed;
  } cfg_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  cfg_t              cfg;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] sig_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  n_q;
  logic              start_q;
  logic              start_eff;
  logic              abort_eff;
  logic              start_ev;
  logic              unused_la;

  assign cfg       = cfg_t'(la_data_in[2*LFSR_W+CNT_W-1:0]);
  assign start_eff = la_data_in[96] & ~la_oenb[96];
  assign abort_eff = la_data_in[97] & ~la_oenb[97];
  assign start_ev  = start_eff & ~start_q;
  assign unused_la = ^{la_data_in[127:98], la_data_in[95:2*LFSR_W+CNT_W],
                       la_oenb[127:98], la_oenb[95:0]};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_eff;
    end
  end

  // Abort outranks everything, including a simultaneous start edge.
  always_comb begin
    state_d = state_q;
    if (abort_eff) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (start_ev) state_d = LOAD;
        LOAD:      state_d = (cfg.n != '0) ? RUN : CMP;
        RUN:       if (cnt_q == n_q - CNT_ONE) state_d = CMP;
        CMP:       state_d = (lfsr_q == sig_q) ? PASS : FAIL;
        PASS,
        FAIL:      if (start_ev) state_d = LOAD;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Datapath freezes on abort so firmware can read where the run stopped.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      lfsr_q <= '0;
      sig_q  <= '0;
      cnt_q  <= '0;
      n_q    <= '0;
    end else if (!abort_eff) begin
      if (state_q == LOAD) begin
        lfsr_q <= cfg.seed;
        sig_q  <= cfg.sig;
        n_q    <= cfg.n;
        cnt_q  <= '0;
      end else if (state_q == RUN) begin
        lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
        cnt_q  <= cnt_q + CNT_ONE;
      end
    end
  end

  always_comb begin
    la_data_out                          = '0;
    la_data_out[LFSR_W-1:0]              = lfsr_q;
    la_data_out[LFSR_W+CNT_W-1:LFSR_W]   = cnt_q;
    la_data_out[49]                      = (state_q == PASS);
    la_data_out[48]                      = (state_q == FAIL);
    la_data_out[52:50]                   = state_q;
  end

  always_comb begin
    io_out        = '0;
    io_out[37]    = (state_q == PASS);
    io_out[36]    = (state_q == FAIL);
    io_out[25:20] = {3'b000, state_q};
  end

  always_comb begin
    io_oeb        = '1;
    io_oeb[37:36] = 2'b00;
    io_oeb[25:20] = 6'b000000;
  end

endmodule

// File: doc/la_lfsr_selftest.md
Name: la_lfsr_selftest

Overview:
- User-project block inside user_project_wrapper, controlled entirely through Caravel logic-analyzer (LA) probes by the la_test4 firmware.
- Firmware loads a seed, a step count and an expected signature, then pulses start. The block clocks a Galois LFSR for the requested number of steps and compares the result with the expected signature.
- Pass/fail is driven on mprj_io[37:36] and the FSM state on mprj_io[25:20], which the testbench monitors.

Parameters:
- LFSR_W, 32, LFSR/seed/signature width (LA field mapping below assumes 32)
- POLY, 32'h80200003, Galois feedback mask
- CNT_W, 16, step-count width

Ports:
- wb_clk_i  input  1  system clock
- wb_rst_i  input  1  synchronous active-high reset
- la_data_in  input  128  LA data from firmware
- la_oenb  input  128  LA output-enable-bar; 0 = firmware drives that bit
- la_data_out  output  128  LA readback to firmware
- io_out  output  38  mprj_io output values
- io_oeb  output  38  mprj_io output-enable-bar

Behaviour:
- LA input map:
  - [31:0] seed
  - [63:32] expected signature
  - [79:64] step count N
  - [96] start
  - [97] abort
- A control bit is effective only when its la_oenb bit is 0: start_eff = la_data_in[96] & ~la_oenb[96]; abort_eff likewise with bit 97.
- Start detection: start_eff is registered each cycle; a start event is a rising edge, i.e. start_eff=1 while the previous registered value was 0. A held-high start never retriggers.
- State encoding (3 bits): IDLE=0, LOAD=1, RUN=2, CMP=3, PASS=4, FAIL=5.
- Transitions:
  - IDLE -> LOAD on a start event.
  - LOAD: latch seed into lfsr, expected into sig_q, N into n_q; clear cnt. Next state is RUN if N!=0, else CMP.
  - RUN: each cycle lfsr <= (lfsr>>1) ^ (lfsr[0] ? POLY : 0) and cnt <= cnt+1. After the step where cnt == n_q-1, go to CMP. RUN therefore lasts exactly N cycles.
  - CMP: PASS if lfsr == sig_q, else FAIL. Single cycle.
  - PASS/FAIL: hold until a start event (-> LOAD) or abort (-> IDLE).
- abort_eff in LOAD/RUN/CMP/PASS/FAIL -> IDLE next cycle; lfsr and cnt keep their values.
- Start and abort active in the same cycle: abort wins.
- Latency: start edge seen in cycle T -> LOAD at T+1, CMP at T+N+2, PASS/FAIL at T+N+3.
- Inputs are latched in LOAD only. LA changes during RUN/CMP have no effect.
- cnt wraps modulo 2^CNT_W. N=0xFFFF is legal and runs 65535 steps.
- A zero seed is legal and yields 0 for any N.
- la_data_out map:
  - [31:0] lfsr
  - [47:32] cnt
  - [49:48] status {pass,fail}
  - [52:50] state
  - all other bits 0
- io_out map:
  - [37:36]: 2'b10 in PASS, 2'b01 in FAIL, 2'b00 otherwise
  - [25:20]: {3'b000, state}
  - all other bits 0
- io_oeb: bits 37:36 and 25:20 = 0 (driven); all other bits = 1.
- Reset (wb_rst_i=1 at a clock edge, any state, including mid-RUN):
  - state IDLE; lfsr, cnt, sig_q, n_q and start edge register cleared.
  - la_data_out = 0; io_out = 0.
  - io_oeb holds its constant value above.
- All outputs are registered or decoded from registered state only; no combinational path from la_data_in to outputs.

Test Plan:
- Reset then idle: wb_rst_i high 4 cycles, then low -> io_out[25:20]=0, io_out[37:36]=2'b00, la_data_out=0, io_oeb[37:36]=0, io_oeb[0]=1.
- Single step pass: seed=1, N=1, expected=32'h80200003, start 0->1 -> PASS 4 cycles after the edge; io_out[37:36]=2'b10; la_data_out[31:0]=32'h80200003; cnt=1.
- Two steps fail: seed=1, N=2, expected=32'h0 -> FAIL; lfsr readback 32'hC0300002; io_out[37:36]=2'b01; io_out[25:20]=5.
- N=0 and gating:
  - seed=32'hDEADBEEF, N=0, expected=32'hDEADBEEF -> LOAD->CMP->PASS, RUN never entered.
  - Repeat with la_oenb[96]=1 -> no start, state stays 0.
- Abort/priority:
  - N=100; assert abort at RUN cycle 10 -> state IDLE next cycle, cnt=10.
  - Start and abort pulsed together from IDLE -> stays IDLE.
- Reset mid-run and retrigger:
  - wb_rst_i during RUN -> IDLE, all readbacks 0.
  - From PASS, a new start edge with changed seed -> LOAD, new result.
  - start held high after completion -> no rerun.
